reorder_buffer: RTL and testbench

- Tracks in-flight instructions in program order from rename/dispatch to retirement.
- Allocates a ROB slot per dispatched instruction; the slot index travels with the op through the execution buffer and back on completion.
- Retires completed instructions strictly in order, one per cycle.
- At retirement, emits the previous physical D/S register mappings so the free list can reclaim them.

---
 rtl/reorder_buffer_pkg.sv | 38 +++
 rtl/reorder_buffer_if.sv | 71 +++++++
 rtl/reorder_buffer.sv | 128 ++++++++++++
 tb/tb_reorder_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer_pkg
//  Description : Shared sizing constants and the canonical ROB entry type
//                used by the reorder buffer and its neighbours (dispatch,
//                execution buffer, free list).
//  Contents    : NUM_D_REG / NUM_S_REG  - physical register file depths
//                ROB_SIZE               - default number of ROB entries
//                PHYS_D_W / PHYS_S_W    - physical register index widths
//                ROB_ADDR_W             - ROB slot index width carried by ops
//                rob_entry              - packed entry at default widths
//  Revision    : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

  localparam int NUM_D_REG  = 64;
  localparam int NUM_S_REG  = 32;
  localparam int ROB_SIZE   = 16;

  localparam int PHYS_D_W   = $clog2(NUM_D_REG);
  localparam int PHYS_S_W   = $clog2(NUM_S_REG);

  // Width of the slot index that travels with an op through the execution
  // buffer and comes back on completion.
  localparam int ROB_ADDR_W = $clog2(ROB_SIZE);

  typedef struct packed {
    logic                valid;
    logic                done;
    logic                write_dst;
    logic [PHYS_D_W-1:0] rw_addr;
    logic [PHYS_D_W-1:0] prev_rw_addr;
    logic [PHYS_S_W-1:0] rs_addr;
    logic [PHYS_S_W-1:0] prev_rs_addr;
  } rob_entry;

endpackage : reorder_buffer_pkg
`default_nettype wire

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer_if
//  Description : Bundle of the dispatch (alloc), writeback (complete),
//                retirement (commit), flush and occupancy signals of the
//                reorder buffer.
//  Modports    : master - dispatch/writeback/retire side: drives alloc_*,
//                         complete_*, flush; observes ready, commit_*, count
//                slave  - the reorder buffer itself
//  Parameters  : L   - number of ROB entries (power of 2, >= 2)
//                D_W - physical D-register index width
//                S_W - physical S-register index width
//  Revision    : 1.0 - initial release
// ============================================================================
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int L   = ROB_SIZE,
  parameter int D_W = PHYS_D_W,
  parameter int S_W = PHYS_S_W
);

  // allocate (dispatch)
  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [$clog2(L)-1:0] alloc_rob_addr;
  logic                 alloc_write_dst;
  logic [D_W-1:0]       alloc_rw_addr;
  logic [D_W-1:0]       alloc_prev_rw_addr;
  logic [S_W-1:0]       alloc_rs_addr;
  logic [S_W-1:0]       alloc_prev_rs_addr;

  // complete (writeback)
  logic                 complete_valid;
  logic [$clog2(L)-1:0] complete_rob_addr;

  // squash
  logic                 flush;

  // commit (retirement)
  logic                 commit_valid;
  logic [$clog2(L)-1:0] commit_rob_addr;
  logic                 commit_write_dst;
  logic [D_W-1:0]       commit_rw_addr;
  logic [D_W-1:0]       commit_prev_rw_addr;
  logic [S_W-1:0]       commit_rs_addr;
  logic [S_W-1:0]       commit_prev_rs_addr;

  // occupancy
  logic [$clog2(L):0]   count;

  modport master (
    output alloc_valid, alloc_write_dst, alloc_rw_addr, alloc_prev_rw_addr,
           alloc_rs_addr, alloc_prev_rs_addr,
           complete_valid, complete_rob_addr, flush,
    input  alloc_ready, alloc_rob_addr,
           commit_valid, commit_rob_addr, commit_write_dst, commit_rw_addr,
           commit_prev_rw_addr, commit_rs_addr, commit_prev_rs_addr, count
  );

  modport slave (
    input  alloc_valid, alloc_write_dst, alloc_rw_addr, alloc_prev_rw_addr,
           alloc_rs_addr, alloc_prev_rs_addr,
           complete_valid, complete_rob_addr, flush,
    output alloc_ready, alloc_rob_addr,
           commit_valid, commit_rob_addr, commit_write_dst, commit_rw_addr,
           commit_prev_rw_addr, commit_rs_addr, commit_prev_rs_addr, count
  );

endinterface : reorder_buffer_if
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer
//  Description : Circular buffer tracking in-flight instructions in program
//                order. Dispatch allocates a slot at the tail, writeback marks
//                a slot done, and the head retires in order (one per cycle)
//                presenting the previous physical mappings for reclamation.
//  Ports       : clk   - clock, rising edge
//                rst_n - synchronous active-low reset
//                rob   - reorder_buffer_if.slave (alloc / complete / flush /
//                        commit / count)
//  Parameters  : L   - number of entries, power of 2 and >= 2
//                D_W - physical D-register index width
//                S_W - physical S-register index width
//  Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int L   = ROB_SIZE,
  parameter int D_W = PHYS_D_W,
  parameter int S_W = PHYS_S_W
)(
  input  logic            clk,
  input  logic            rst_n,
  reorder_buffer_if.slave rob
);

  localparam int IW = $clog2(L);
  localparam int PW = IW + 1;   // pointer carries a wrap bit above the index

  // Payload lives in a plain array without reset; valid/done are the only
  // bits that need clearing and are kept as flat vectors for that reason.
  typedef struct packed {
    logic           write_dst;
    logic [D_W-1:0] rw_addr;
    logic [D_W-1:0] prev_rw_addr;
    logic [S_W-1:0] rs_addr;
    logic [S_W-1:0] prev_rs_addr;
  } payload_t;

  payload_t       payload_q [L];
  logic [L-1:0]   valid_q;
  logic [L-1:0]   done_q;
  logic [PW-1:0]  head_q;
  logic [PW-1:0]  tail_q;

  logic [IW-1:0]  head_idx;
  logic [IW-1:0]  tail_idx;
  logic           full;
  logic           do_alloc;
  logic           do_complete;
  logic           do_commit;

  assign head_idx = head_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];

  // Full when indices match but the wrap bits differ. Derived from
  // registered pointers only, so a retirement this cycle frees space
  // for dispatch starting next cycle.
  assign full        = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);

  assign do_alloc    = rob.alloc_valid & ~full & ~rob.flush;
  assign do_complete = rob.complete_valid & ~rob.flush & valid_q[rob.complete_rob_addr];
  assign do_commit   = ~rob.flush & valid_q[head_idx] & done_q[head_idx];

  // ---------------------------------------------------------------- outputs
  assign rob.alloc_ready         = ~full;
  assign rob.alloc_rob_addr      = tail_idx;
  assign rob.count               = tail_q - head_q;

  assign rob.commit_valid        = do_commit;
  assign rob.commit_rob_addr     = head_idx;
  assign rob.commit_write_dst    = payload_q[head_idx].write_dst;
  assign rob.commit_rw_addr      = payload_q[head_idx].rw_addr;
  assign rob.commit_prev_rw_addr = payload_q[head_idx].prev_rw_addr;
  assign rob.commit_rs_addr      = payload_q[head_idx].rs_addr;
  assign rob.commit_prev_rs_addr = payload_q[head_idx].prev_rs_addr;

  // ------------------------------------------------- pointers and status bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else if (rob.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      // Order matters: a completion aimed at the head that is retiring in
      // the same cycle must not leave a stale done bit behind, so the
      // commit clear is written after it. Alloc never targets a valid slot
      // (tail slot is free whenever alloc is accepted), so it cannot
      // collide with either.
      if (do_complete) begin
        done_q[rob.complete_rob_addr] <= 1'b1;
      end
      if (do_commit) begin
        valid_q[head_idx] <= 1'b0;
        done_q[head_idx]  <= 1'b0;
        head_q            <= head_q + PW'(1);
      end
      if (do_alloc) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        tail_q            <= tail_q + PW'(1);
      end
    end
  end

  // ------------------------------------------------------------ payload RAM
  always_ff @(posedge clk) begin
    if (rst_n && do_alloc) begin
      payload_q[tail_idx] <= '{
        write_dst:    rob.alloc_write_dst,
        rw_addr:      rob.alloc_rw_addr,
        prev_rw_addr: rob.alloc_prev_rw_addr,
        rs_addr:      rob.alloc_rs_addr,
        prev_rs_addr: rob.alloc_prev_rs_addr
      };
    end
  end

endmodule : reorder_buffer
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reorder_buffer
//  Description : Directed self-checking bench for reorder_buffer (L=16).
//                Inputs change just after the falling edge; outputs are
//                sampled before the next rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int L   = 16;
  localparam int D_W = 6;
  localparam int S_W = 5;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_err;

  reorder_buffer_if #(.L(L), .D_W(D_W), .S_W(S_W)) rob_bus ();

  reorder_buffer #(.L(L), .D_W(D_W), .S_W(S_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rob   (rob_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rob_bus.alloc_valid        = 1'b0;
    rob_bus.alloc_write_dst    = 1'b0;
    rob_bus.alloc_rw_addr      = '0;
    rob_bus.alloc_prev_rw_addr = '0;
    rob_bus.alloc_rs_addr      = '0;
    rob_bus.alloc_prev_rs_addr = '0;
    rob_bus.complete_valid     = 1'b0;
    rob_bus.complete_rob_addr  = '0;
    rob_bus.flush              = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic set_alloc(input int wd, input int rw, input int prw, input int rs, input int prs);
    rob_bus.alloc_valid        = 1'b1;
    rob_bus.alloc_write_dst    = 1'(wd);
    rob_bus.alloc_rw_addr      = D_W'(rw);
    rob_bus.alloc_prev_rw_addr = D_W'(prw);
    rob_bus.alloc_rs_addr      = S_W'(rs);
    rob_bus.alloc_prev_rs_addr = S_W'(prs);
  endtask

  task automatic alloc(input int wd, input int rw, input int prw, input int rs, input int prs);
    set_alloc(wd, rw, prw, rs, prs);
    cyc();
    rob_bus.alloc_valid = 1'b0;
  endtask

  task automatic complete(input int slot);
    rob_bus.complete_valid    = 1'b1;
    rob_bus.complete_rob_addr = 4'(slot);
    cyc();
    rob_bus.complete_valid    = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;

    // ---------------------------------------------------------- reset state
    check("rst_ready",  32'(rob_bus.alloc_ready),    1);
    check("rst_addr",   32'(rob_bus.alloc_rob_addr), 0);
    check("rst_count",  32'(rob_bus.count),          0);
    check("rst_commit", 32'(rob_bus.commit_valid),   0);
    cyc();
    check("idle_count", 32'(rob_bus.count),          0);

    // ------------------------------------------- in-order commit, 3 entries
    for (int i = 0; i < 3; i++) begin
      check("alloc_addr", 32'(rob_bus.alloc_rob_addr), 32'(i));
      alloc(1, 5 + i, 1 + i, 10 + i, 20 + i);
    end
    check("a3_count",  32'(rob_bus.count),        3);
    check("a3_commit", 32'(rob_bus.commit_valid), 0);
    complete(1);
    check("c1_nocommit", 32'(rob_bus.commit_valid), 0);
    rob_bus.complete_valid    = 1'b1;
    rob_bus.complete_rob_addr = 4'd0;
    #1;
    check("c0_registered", 32'(rob_bus.commit_valid), 0);
    cyc();
    rob_bus.complete_valid = 1'b0;
    check("cm0_valid",   32'(rob_bus.commit_valid),        1);
    check("cm0_addr",    32'(rob_bus.commit_rob_addr),     0);
    check("cm0_wd",      32'(rob_bus.commit_write_dst),    1);
    check("cm0_rw",      32'(rob_bus.commit_rw_addr),      5);
    check("cm0_prev_rw", 32'(rob_bus.commit_prev_rw_addr), 1);
    check("cm0_rs",      32'(rob_bus.commit_rs_addr),      10);
    check("cm0_prev_rs", 32'(rob_bus.commit_prev_rs_addr), 20);
    cyc();
    check("cm1_valid",   32'(rob_bus.commit_valid),        1);
    check("cm1_addr",    32'(rob_bus.commit_rob_addr),     1);
    check("cm1_prev_rw", 32'(rob_bus.commit_prev_rw_addr), 2);
    check("cm1_count",   32'(rob_bus.count),               2);
    cyc();
    check("s2_wait",     32'(rob_bus.commit_valid),        0);
    check("s2_count",    32'(rob_bus.count),               1);
    cyc();
    check("s2_hold",     32'(rob_bus.commit_valid),        0);
    complete(2);
    check("cm2_valid",   32'(rob_bus.commit_valid),        1);
    check("cm2_prev_rw", 32'(rob_bus.commit_prev_rw_addr), 3);
    cyc();
    check("drain_count", 32'(rob_bus.count),               0);
    check("drain_cv",    32'(rob_bus.commit_valid),        0);

    // ------------------------------------------------------- full and wrap
    do_reset();
    for (int i = 0; i < 16; i++) alloc(1, i, i + 16, i, i + 16);
    check("full_count", 32'(rob_bus.count),          16);
    check("full_ready", 32'(rob_bus.alloc_ready),    0);
    check("full_addr",  32'(rob_bus.alloc_rob_addr), 0);
    alloc(1, 63, 63, 31, 31);
    check("ovf_count",  32'(rob_bus.count),          16);
    check("ovf_commit", 32'(rob_bus.commit_valid),   0);
    complete(0);
    check("fc0_valid",   32'(rob_bus.commit_valid),        1);
    check("fc0_prev_rw", 32'(rob_bus.commit_prev_rw_addr), 16);
    check("fc0_ready",   32'(rob_bus.alloc_ready),         0);
    cyc();
    check("open_ready",  32'(rob_bus.alloc_ready),         1);
    check("open_count",  32'(rob_bus.count),               15);
    check("open_addr",   32'(rob_bus.alloc_rob_addr),      0);
    alloc(1, 40, 41, 7, 8);
    check("wrap_count",  32'(rob_bus.count),               16);
    check("wrap_ready",  32'(rob_bus.alloc_ready),         0);
    check("wrap_addr",   32'(rob_bus.alloc_rob_addr),      1);

    // ---------------------------------- full: alloc and commit same cycle
    complete(1);
    set_alloc(1, 50, 51, 9, 9);
    #1;
    check("ac_ready",   32'(rob_bus.alloc_ready),         0);
    check("ac_commit",  32'(rob_bus.commit_valid),        1);
    check("ac_addr",    32'(rob_bus.commit_rob_addr),     1);
    check("ac_prev_rw", 32'(rob_bus.commit_prev_rw_addr), 17);
    cyc();
    rob_bus.alloc_valid = 1'b0;
    check("ac_count",   32'(rob_bus.count),               15);
    check("ac_tail",    32'(rob_bus.alloc_rob_addr),      1);
    check("ac_head",    32'(rob_bus.commit_rob_addr),     2);

    // ---------------------------------------------------------------- flush
    do_reset();
    for (int i = 0; i < 5; i++) alloc(1, i + 1, i + 2, i, i);
    complete(0);
    check("fl_pre_cv", 32'(rob_bus.commit_valid), 1);
    rob_bus.flush             = 1'b1;
    rob_bus.complete_valid    = 1'b1;
    rob_bus.complete_rob_addr = 4'd3;
    #1;
    check("fl_cv", 32'(rob_bus.commit_valid), 0);
    cyc();
    rob_bus.flush          = 1'b0;
    rob_bus.complete_valid = 1'b0;
    check("fl_count", 32'(rob_bus.count),          0);
    check("fl_addr",  32'(rob_bus.alloc_rob_addr), 0);
    check("fl_ready", 32'(rob_bus.alloc_ready),    1);
    for (int i = 0; i < 4; i++) alloc(1, i, i, i, i);
    check("fl_after_cv", 32'(rob_bus.commit_valid), 0);
    for (int i = 0; i < 3; i++) complete(i);
    cyc();
    check("fl_s3_head", 32'(rob_bus.commit_rob_addr), 3);
    check("fl_s3_cv",   32'(rob_bus.commit_valid),    0);

    // ------------------------------------- completion to unallocated slot
    do_reset();
    alloc(1, 1, 2, 3, 4);
    alloc(1, 2, 3, 4, 5);
    complete(9);
    check("un_cv", 32'(rob_bus.commit_valid), 0);
    for (int i = 2; i < 9; i++) alloc(1, i, i, i, i);
    alloc(0, 33, 34, 17, 18);
    check("un_count", 32'(rob_bus.count), 10);
    for (int i = 0; i < 9; i++) complete(i);
    check("un_cm8_cv",   32'(rob_bus.commit_valid),    1);
    check("un_cm8_addr", 32'(rob_bus.commit_rob_addr), 8);
    cyc();
    check("un_s9_head",  32'(rob_bus.commit_rob_addr), 9);
    check("un_s9_cv",    32'(rob_bus.commit_valid),    0);
    check("un_s9_count", 32'(rob_bus.count),           1);
    complete(9);
    check("un_cm9_cv",      32'(rob_bus.commit_valid),        1);
    check("un_cm9_wd",      32'(rob_bus.commit_write_dst),    0);
    check("un_cm9_prev_rw", 32'(rob_bus.commit_prev_rw_addr), 34);
    check("un_cm9_prev_rs", 32'(rob_bus.commit_prev_rs_addr), 18);

    // --------------------------------------- reset overrides mid-stream
    rob_bus.alloc_valid = 1'b1;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    rob_bus.alloc_valid = 1'b0;
    check("mrst_count", 32'(rob_bus.count),        0);
    check("mrst_cv",    32'(rob_bus.commit_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_reorder_buffer
`default_nettype wire
